lsu_ram_port: RTL and testbench

LSU_RAM_PORT -- requirements
Module: lsu_ram_port

---
 rtl/lsu_ram_port.sv | 180 ++++++++++++++++++
 tb/tb_lsu_ram_port.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ram_port.sv
// Load/store unit port onto a single-ported word RAM with a registered read output.
// Sub-word stores are done as read-modify-write; misaligned or out-of-range requests are rejected.
module lsu_ram_port #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [31:0]           ram_rdata
);

  localparam int unsigned AW2 = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdWait,
    StRmwRd,
    StRmwWait,
    StWr,
    StResp
  } state_e;

  state_e         r_state;
  state_e         w_state_next;
  logic           r_we;
  logic [2:0]     r_funct3;
  logic [AW2-1:0] r_addr;
  logic [31:0]    r_merge;

  logic           w_accept;
  logic           w_err;
  logic [1:0]     w_off;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_load;
  logic [31:0]    w_merged;

  assign w_accept = req_valid && req_ready;

  // Request classification, only meaningful in the accept cycle.
  always_comb begin
    w_err = 1'b0;
    if ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)) w_err = 1'b1;
    if (req_we && req_funct3[2]) w_err = 1'b1;
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) w_err = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) w_err = 1'b1;
    if ((req_addr >> AW2) != 32'd0) w_err = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_next = StResp;
          end else if (!req_we) begin
            w_state_next = StRd;
          end else if (req_funct3[1:0] == 2'b10) begin
            w_state_next = StWr;
          end else begin
            w_state_next = StRmwRd;
          end
        end
      end
      StRd:      w_state_next = StRdWait;
      StRdWait:  w_state_next = StResp;
      StRmwRd:   w_state_next = StRmwWait;
      StRmwWait: w_state_next = StWr;
      StWr:      w_state_next = StResp;
      StResp:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (r_state == StIdle) && !rst;
    rsp_valid = (r_state == StResp) && !rst;
    ram_re    = !rst && ((r_state == StRd) || (r_state == StRmwRd));
    ram_we    = !rst && (r_state == StWr) && r_we;
    ram_addr  = '0;
    if ((r_state == StRd) || (r_state == StRmwRd) || (r_state == StWr)) begin
      ram_addr = r_addr[AW2-1:2];
    end
    ram_wdata = (r_state == StWr) ? r_merge : 32'd0;
  end

  assign w_off = r_addr[1:0];

  // Lane extraction for loads (little-endian).
  always_comb begin
    w_byte = ram_rdata[7:0];
    case (w_off)
      2'd0:    w_byte = ram_rdata[7:0];
      2'd1:    w_byte = ram_rdata[15:8];
      2'd2:    w_byte = ram_rdata[23:16];
      default: w_byte = ram_rdata[31:24];
    endcase
    w_half = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = ram_rdata;
    endcase
  end

  // Store data sits in r_merge from accept; its low lanes are spliced into the old word.
  always_comb begin
    w_merged = ram_rdata;
    if (r_funct3[1:0] == 2'b00) begin
      case (w_off)
        2'd0:    w_merged[7:0]   = r_merge[7:0];
        2'd1:    w_merged[15:8]  = r_merge[7:0];
        2'd2:    w_merged[23:16] = r_merge[7:0];
        default: w_merged[31:24] = r_merge[7:0];
      endcase
    end else if (r_funct3[1:0] == 2'b01) begin
      if (r_addr[1]) begin
        w_merged[31:16] = r_merge[15:0];
      end else begin
        w_merged[15:0] = r_merge[15:0];
      end
    end else begin
      w_merged = r_merge;
    end
  end

  // Response fields only change on the edge that enters StResp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= '0;
      r_merge   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[AW2-1:0];
        if (req_we) r_merge <= req_wdata;
        if (w_err) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= 32'd0;
        end
      end
      case (r_state)
        StRdWait: begin
          rsp_rdata <= w_load;
          rsp_err   <= 1'b0;
        end
        StRmwWait: r_merge <= w_merged;
        StWr: begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ram_port.sv
// Bench for lsu_ram_port: behavioural RAM, reference model and response scoreboard.
module tb_lsu_ram_port;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   ram_rdata;

  always #5 clk = ~clk;

  lsu_ram_port #(.ADDR_WIDTH(AW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          n_re;
    int          n_we;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  logic [31:0] mem       [1024] = '{default: 32'h0};
  logic [31:0] model_mem [1024] = '{default: 32'h0};

  exp_t exp_q[$];
  int   acc_cyc_q[$];
  int   acc_re_q[$];
  int   acc_we_q[$];
  int   cyc = 0;
  int   n_re = 0;
  int   n_we = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Registered-output RAM.
  initial forever begin
    @(posedge clk);
    if (ram_re === 1'b1) ram_rdata <= mem[ram_addr];
    if (ram_we === 1'b1) mem[ram_addr] = ram_wdata;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  initial forever begin
    exp_t e;
    int   a_cyc;
    int   a_re;
    int   a_we;
    @(negedge clk);
    if ((ram_re === 1'b1) && (ram_we === 1'b1)) check_eq("re_we_both", ram_we, 1'b0);
    if ((ram_we === 1'b1) && (exp_q.size() > 0)) begin
      check_eq("ram_waddr", 32'(ram_addr), exp_q[0].waddr);
      check_eq("ram_wdata", ram_wdata, exp_q[0].wdata);
    end
    if (ram_re === 1'b1) n_re++;
    if (ram_we === 1'b1) n_we++;
    if (rsp_valid === 1'b1) begin
      if ((exp_q.size() == 0) || (acc_cyc_q.size() == 0)) begin
        check_eq("spurious_rsp", rsp_valid, 1'b0);
      end else begin
        e     = exp_q.pop_front();
        a_cyc = acc_cyc_q.pop_front();
        a_re  = acc_re_q.pop_front();
        a_we  = acc_we_q.pop_front();
        check_eq("latency", 32'(cyc - a_cyc), 32'(e.lat));
        check_eq("rsp_err", rsp_err, e.err);
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("ram_re_count", 32'(n_re - a_re), 32'(e.n_re));
        check_eq("ram_we_count", 32'(n_we - a_we), 32'(e.n_we));
      end
    end
    if ((req_valid === 1'b1) && (req_ready === 1'b1)) begin
      acc_cyc_q.push_back(cyc);
      acc_re_q.push_back(n_re);
      acc_we_q.push_back(n_we);
    end
  end

  // Reference model; updates model_mem for accepted stores.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output exp_t e);
    logic [31:0] w;
    logic [31:0] sh;
    logic [31:0] hw;
    logic [31:0] mask;
    logic [31:0] data;
    w     = model_mem[addr[11:2]];
    e.err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]) ||
            ((f3[1:0] == 2'b01) && addr[0]) ||
            ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) || (addr[31:12] != 20'd0);
    e.rdata = 32'd0;
    e.n_re  = 0;
    e.n_we  = 0;
    e.waddr = {22'd0, addr[11:2]};
    e.wdata = 32'd0;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat  = 3;
      e.n_re = 1;
      sh     = w >> {addr[1:0], 3'b000};
      hw     = w >> {addr[1], 4'b0000};
      case (f3)
        3'b000:  e.rdata = {{24{sh[7]}}, sh[7:0]};
        3'b100:  e.rdata = {24'd0, sh[7:0]};
        3'b001:  e.rdata = {{16{hw[15]}}, hw[15:0]};
        3'b101:  e.rdata = {16'd0, hw[15:0]};
        default: e.rdata = w;
      endcase
    end else begin
      e.n_we = 1;
      if (f3[1:0] == 2'b10) begin
        e.lat   = 2;
        e.wdata = wdata;
      end else begin
        e.lat  = 4;
        e.n_re = 1;
        if (f3[1:0] == 2'b00) begin
          mask = 32'h0000_00FF << {addr[1:0], 3'b000};
          data = wdata << {addr[1:0], 3'b000};
        end else begin
          mask = 32'h0000_FFFF << {addr[1], 4'b0000};
          data = wdata << {addr[1], 4'b0000};
        end
        e.wdata = (w & ~mask) | (data & mask);
      end
      model_mem[addr[11:2]] = e.wdata;
    end
  endtask

  task automatic wait_drain();
    int budget = 0;
    while ((exp_q.size() != 0) && (budget < 20)) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      check_eq("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      acc_cyc_q.delete();
      acc_re_q.delete();
      acc_we_q.delete();
    end
  endtask

  task automatic wait_ready(output logic ok);
    int budget = 0;
    @(negedge clk);
    while (!req_ready && (budget < 20)) begin
      @(negedge clk);
      budget++;
    end
    ok = req_ready;
    if (!ok) check_eq("accept_timeout", req_ready, 1'b1);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    exp_t e;
    logic ok;
    @(posedge clk);
    #1;
    model_req(we, f3, addr, wdata, e);
    exp_q.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    wait_ready(ok);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    // Scramble the request bus while busy; it must be ignored.
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    if (!ok) exp_q.delete();
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    exp_t e2;
    logic ok;
    int   acc1;
    int   acc2;
    int   we_before;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", req_ready, 1'b0);
    check_eq("rst_ram_re", ram_re, 1'b0);
    check_eq("rst_ram_we", ram_we, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", req_ready, 1'b1);
    check_eq("idle_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("idle_rsp_err", rsp_err, 1'b0);
    check_eq("idle_ram_addr", 32'(ram_addr), 32'd0);

    // Word store/load and sub-word loads.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    do_req(1'b0, 3'b000, 32'h13, 32'h0);
    do_req(1'b0, 3'b100, 32'h13, 32'h0);
    do_req(1'b0, 3'b001, 32'h12, 32'h0);
    do_req(1'b0, 3'b101, 32'h10, 32'h0);
    // Read-modify-write stores.
    do_req(1'b1, 3'b000, 32'h11, 32'h0000_0055);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(1'b1, 3'b001, 32'h12, 32'hABCD_1234);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    // Rejected requests.
    do_req(1'b0, 3'b010, 32'h12, 32'h0);
    do_req(1'b1, 3'b001, 32'h11, 32'h1111);
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    do_req(1'b0, 3'b010, 32'h1000, 32'h0);
    do_req(1'b1, 3'b100, 32'h10, 32'h22);

    // Reset while an SB sits in RMW_WAIT.
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h11;
    req_wdata  = 32'hAA;
    we_before  = n_we;
    wait_ready(ok);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_cyc_q.delete();
    acc_re_q.delete();
    acc_we_q.delete();
    @(negedge clk);
    check_eq("ready_after_rst", req_ready, 1'b1);
    repeat (6) @(negedge clk);
    check_eq("no_we_after_rst", 32'(n_we), 32'(we_before));
    do_req(1'b0, 3'b010, 32'h10, 32'h0);

    // Two loads with req_valid held high.
    @(posedge clk);
    #1;
    model_req(1'b0, 3'b010, 32'h10, 32'h0, e1);
    model_req(1'b0, 3'b100, 32'h13, 32'h0, e2);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    wait_ready(ok);
    acc1 = cyc;
    @(posedge clk);
    #1;
    req_funct3 = 3'b100;
    req_addr   = 32'h13;
    wait_ready(ok);
    acc2 = cyc;
    check_eq("hold_accept_gap", 32'(acc2 - acc1), 32'd4);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_drain();

    // Random mix over a small window, with occasional out-of-range addresses.
    repeat (40) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) r_addr = r_addr | (32'h1000 << $urandom_range(0, 19));
      do_req(r_we, r_f3, r_addr, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
